fproc_iface: RTL and testbench

- Handshake bridge between the core controller's function-processor request and the external function processor (fproc).
- On the controller's request strobe it:
  - issues a registered request carrying the function ID;
  - waits for the fproc response;
  - returns a one-cycle fproc_ready and holds the response data for the ALU in1 fproc input.
- A timeout guard keeps the controller's fproc wait states from hanging.

---
 rtl/fproc_iface_if.sv | 27 ++
 rtl/fproc_iface.sv | 128 ++++++++++++
 tb/tb_fproc_iface.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fproc_iface_if.sv
// Request/response bus between the core-side fproc bridge and the external function processor.
interface fproc_iface_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int FUNC_ID_WIDTH = 8
);
    logic                     fproc_req_valid;
    logic [FUNC_ID_WIDTH-1:0] fproc_req_id;
    logic                     fproc_req_ack;
    logic                     fproc_resp_valid;
    logic [DATA_WIDTH-1:0]    fproc_resp_data;

    modport master (
        output fproc_req_valid,
        output fproc_req_id,
        input  fproc_req_ack,
        input  fproc_resp_valid,
        input  fproc_resp_data
    );

    modport slave (
        input  fproc_req_valid,
        input  fproc_req_id,
        output fproc_req_ack,
        output fproc_resp_valid,
        output fproc_resp_data
    );
endinterface

// File: rtl/fproc_iface.sv
// Bridges the controller's fproc request strobe to the external function processor,
// with a timeout guard so the controller's wait states can never hang.
module fproc_iface #(
    parameter int DATA_WIDTH     = 32,
    parameter int FUNC_ID_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_stb,
    input  logic [FUNC_ID_WIDTH-1:0] func_id,
    fproc_iface_if.master            fproc,
    output logic                     fproc_ready,
    output logic [DATA_WIDTH-1:0]    fproc_data,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     overrun_err
);

    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] timeout_cnt;
    logic        at_limit;
    logic        accept;
    logic        capture;
    logic        timeout_hit;
    logic        req_valid_d;
    logic        ready_d;
    logic        busy_d;

    assign at_limit = TIMEOUT_EN && (timeout_cnt == TIMEOUT_LAST);
    assign accept   = (state == IDLE) && req_stb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A response always beats a timeout landing in the same cycle.
    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (req_stb) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (fproc.fproc_req_ack && fproc.fproc_resp_valid) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end else if (at_limit) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end else if (fproc.fproc_req_ack) begin
                    state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (fproc.fproc_resp_valid) begin
                    state_next = DONE;
                    capture    = 1'b1;
                end else if (at_limit) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        req_valid_d = (state_next == REQ);
        ready_d     = (state_next == DONE);
        busy_d      = (state_next != IDLE);
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fproc.fproc_req_valid <= 1'b0;
            fproc.fproc_req_id    <= '0;
            fproc_ready           <= 1'b0;
            fproc_data            <= '0;
            busy                  <= 1'b0;
            timeout_err           <= 1'b0;
            overrun_err           <= 1'b0;
            timeout_cnt           <= '0;
        end else begin
            fproc.fproc_req_valid <= req_valid_d;
            fproc_ready           <= ready_d;
            busy                  <= busy_d;
            if (accept) begin
                fproc.fproc_req_id <= func_id;
                timeout_cnt        <= '0;
            end else if (TIMEOUT_EN && ((state == REQ) || (state == WAIT_RESP))) begin
                timeout_cnt <= timeout_cnt + 16'd1;
            end
            if (capture) begin
                fproc_data <= fproc.fproc_resp_data;
            end else if (timeout_hit) begin
                fproc_data <= '0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
            if (req_stb && (state != IDLE)) begin
                overrun_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fproc_iface.sv
// Randomized bench for fproc_iface: each transaction's timeline is derived arithmetically
// from its ack/response cycles and the timeout limit, then compared every cycle.
module tb_fproc_iface;

    localparam int DW = 32;
    localparam int IW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_stb = 1'b0;
    logic [IW-1:0] func_id = '0;
    logic          fproc_ready;
    logic [DW-1:0] fproc_data;
    logic          busy;
    logic          timeout_err;
    logic          overrun_err;

    int            errors = 0;
    int            checks = 0;
    int            txn = 0;
    logic [DW-1:0] data_model = '0;
    bit            terr_model = 1'b0;
    bit            oerr_model = 1'b0;

    fproc_iface_if #(.DATA_WIDTH(DW), .FUNC_ID_WIDTH(IW)) bus ();

    fproc_iface #(
        .DATA_WIDTH(DW),
        .FUNC_ID_WIDTH(IW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_stb(req_stb),
        .func_id(func_id),
        .fproc(bus),
        .fproc_ready(fproc_ready),
        .fproc_data(fproc_data),
        .busy(busy),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input bit exp_valid, input bit exp_busy, input bit exp_ready);
        checkOutput({tag, " req_valid"}, DW'(bus.fproc_req_valid), DW'(exp_valid));
        checkOutput({tag, " busy"}, DW'(busy), DW'(exp_busy));
        checkOutput({tag, " ready"}, DW'(fproc_ready), DW'(exp_ready));
        checkOutput({tag, " data"}, fproc_data, data_model);
        checkOutput({tag, " timeout_err"}, DW'(timeout_err), DW'(terr_model));
        checkOutput({tag, " overrun_err"}, DW'(overrun_err), DW'(oerr_model));
    endtask

    // One request issued at cycle 0; resp_cyc < 0 means the fproc never answers.
    task automatic applyStimulus(input logic [IW-1:0] id, input int ack_cyc, input int resp_cyc,
                                 input logic [DW-1:0] rdata, input int ovr_cyc);
        bit timed_out;
        int done;
        int valid_last;
        timed_out  = (resp_cyc < 0) || (resp_cyc > TO);
        done       = timed_out ? TO : resp_cyc;
        valid_last = (ack_cyc < done) ? ack_cyc : done;
        for (int k = 0; k <= done + 1; k++) begin
            req_stb  = (k == 0) || (k == ovr_cyc);
            func_id  = (k == 0) ? id : ((k == ovr_cyc) ? 8'h22 : IW'($urandom));
            bus.fproc_req_ack    = (k == ack_cyc) && (k <= done);
            bus.fproc_resp_valid = (k == resp_cyc);
            bus.fproc_resp_data  = (k == resp_cyc) ? rdata : DW'($urandom);
            checkAll($sformatf("txn%0d c%0d", txn, k), (k >= 1) && (k <= valid_last),
                     (k >= 1) && (k <= done + 1), k == done + 1);
            if (k >= 1) begin
                checkOutput($sformatf("txn%0d c%0d req_id", txn, k), DW'(bus.fproc_req_id), DW'(id));
            end
            if ((k >= 1) && req_stb) begin
                oerr_model = 1'b1;
            end
            if (k == done) begin
                data_model = timed_out ? '0 : rdata;
                if (timed_out) begin
                    terr_model = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        req_stb              = 1'b0;
        bus.fproc_req_ack    = 1'b0;
        bus.fproc_resp_valid = 1'b0;
        txn++;
    endtask

    // Idle cycles with stray responses that must be ignored.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_stb              = 1'b0;
            bus.fproc_req_ack    = 1'b0;
            bus.fproc_resp_valid = 1'($urandom_range(0, 1));
            bus.fproc_resp_data  = DW'($urandom);
            checkAll($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        bus.fproc_resp_valid = 1'b0;
    endtask

    initial begin
        bus.fproc_req_ack    = 1'b0;
        bus.fproc_resp_valid = 1'b0;
        bus.fproc_resp_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 1'b0, 1'b0, 1'b0);
        checkOutput("reset req_id", DW'(bus.fproc_req_id), '0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(8'h15, 3, 6, 32'hDEADBEEF, 0);
        idleCycles(2);
        applyStimulus(8'hA7, 1, 1, 32'h00001234, 0);
        applyStimulus(8'h3C, 3, TO, 32'hCAFE0008, 0);
        idleCycles(3);
        applyStimulus(8'h33, 2, 6, 32'h0BADF00D, 4);
        applyStimulus(8'h41, 2, -1, 32'h00000000, 0);
        applyStimulus(8'h42, 2, 5, 32'h55AA55AA, 0);
        applyStimulus(8'h43, 1, TO + 1, 32'h77777777, 0);

        for (int n = 0; n < 40; n++) begin
            int a;
            int r;
            int dn;
            int ov;
            a = int'($urandom_range(1, 6));
            if ($urandom_range(0, 3) == 0) begin
                r = -1;
            end else begin
                r = a + int'($urandom_range(0, 5));
            end
            dn = ((r < 0) || (r > TO)) ? TO : r;
            ov = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, dn + 1)) : 0;
            applyStimulus(IW'($urandom), a, r, DW'($urandom), ov);
            if ($urandom_range(0, 1) == 1) begin
                idleCycles(int'($urandom_range(1, 3)));
            end
        end

        // Abort a transaction with an asynchronous reset while it waits for a response.
        req_stb = 1'b1;
        func_id = 8'h5A;
        @(posedge clk);
        #1;
        req_stb           = 1'b0;
        bus.fproc_req_ack = 1'b1;
        checkOutput("abort req_valid", DW'(bus.fproc_req_valid), DW'(1'b1));
        @(posedge clk);
        #1;
        bus.fproc_req_ack = 1'b0;
        checkOutput("abort busy", DW'(busy), DW'(1'b1));
        #3 reset = 1'b1;
        #1;
        data_model = '0;
        terr_model = 1'b0;
        oerr_model = 1'b0;
        checkAll("async reset", 1'b0, 1'b0, 1'b0);
        checkOutput("async reset req_id", DW'(bus.fproc_req_id), '0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        bus.fproc_resp_valid = 1'b1;
        bus.fproc_resp_data  = 32'hFFFF0000;
        checkAll("late resp", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.fproc_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkAll($sformatf("after abort%0d", i), 1'b0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        applyStimulus(8'h77, 2, 3, 32'h13572468, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
